ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Parametrised successor to the fixed 10-key PS/2 controller.
- Consumes synchronised PS/2 scan-code bytes and decodes make, break, E0-extended and E1-pause sequences.
- Tracks press state for NUM_KEYS bus-programmable key slots and queues press/release events in a FIFO.
- Sits between the PS/2 byte synchroniser and the system bus as a memory-mapped peripheral.

Parameters:
- NUM_KEYS, 16, number of programmable key slots; range 1..32.
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
- BUS_WIDTH, 32, bus data width; at least 16.
- ADDR_WIDTH, 6, bus word-address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- code_in  in  8  scan-code byte, already synchronised to clk.
- code_valid  in  1  one-cycle strobe; code_in is valid this cycle.
- bus_addr  in  ADDR_WIDTH  register word address.
- bus_wr  in  1  write strobe.
- bus_rd  in  1  read strobe.
- bus_wdata  in  BUS_WIDTH  write data.
- bus_rdata  out  BUS_WIDTH  read data, registered.
- bus_rvalid  out  1  pulses one cycle after bus_rd.
- irq  out  1  level interrupt.

Behaviour:
- Reset values: bus_rdata=0, bus_rvalid=0, irq=0. Also cleared by reset: all keymap entries (disabled), pressed bitmap, FIFO, overflow flag. Decoder returns to IDLE.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. A state advances only on code_valid.
- From IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, skip counter loaded with 7.
  - Any other byte is a make with ext=0; stay in IDLE.
- From EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Any other byte is a make with ext=1 -> IDLE.
- From BRK: any byte is a break with ext=0 -> IDLE.
- From EXT_BRK: any byte is a break with ext=1 -> IDLE.
- From SKIP: each byte decrements the counter; at 0 -> IDLE. No events are generated while in SKIP.
- Keymap entry format: bit9 enable, bit8 ext, bits7:0 code.
- Matching: a decoded {ext,code} is compared against every enabled entry in parallel. Lowest matching index wins; no match means the byte is ignored.
- Make on a key not yet pressed: set pressed[i] and push event {press=1, idx=i}.
- Make on a key already pressed (typematic repeat): no change, no event.
- Break on a pressed key: clear pressed[i] and push event {press=0, idx=i}.
- Break on a key not pressed: ignored.
- Latency: bitmap and FIFO update on the clock edge after the code_valid cycle carrying the final byte.
- FIFO full on push: event dropped, sticky overflow set. If a pop happens in the same cycle, the push is accepted.
- Register map, word addresses:
  - 0..NUM_KEYS-1: keymap entries, read/write.
  - 0x20: pressed bitmap, read-only.
  - 0x21: event pop, read-only. Returns {valid bit15, press bit8, idx bits4:0}. A read when empty returns 0 and does not pop.
  - 0x22: status, read-only. Returns {overflow bit8, count bits7:0}.
  - 0x23: control, write-only. bit0 clears the bitmap (no events generated); bit1 clears overflow; bit2 flushes the FIFO.
  - Unmapped reads return 0; unmapped writes are ignored.
- Writing a keymap entry clears pressed[] for that slot and generates no event.
- A bus pop and an event push in the same cycle are both honoured; count is unchanged.
- irq = FIFO non-empty OR overflow.
- Bus read latency is exactly 1 cycle; bus_rd and bus_wr are never asserted together.

Optional Feature:
- Macro PS2_KEY_EVENT_FIFO_EN.
- When defined: event FIFO, register 0x21, FIFO count/overflow status and FIFO flush as specified above.
- When undefined:
  - No FIFO is built.
  - 0x21 and 0x22 read 0.
  - A sticky "changed" flag sets on any bitmap change and clears on a read of 0x20.
  - irq = changed.

Decomposition:
- Package ps2_key_pkg holds:
  - Scan-code constants: 0xE0, 0xF0, 0xE1.
  - Decoder state typedef.
  - Register address constants.
  - Keymap entry field positions.
  - Event record layout.
- One sub-module: ps2_code_decoder, containing the FSM and skip counter. It emits a make/break strobe plus {ext,code}.
- The FIFO is inline in ps2_key_tracker.

Test Plan:
- Program slot 0 = {en,0,1D}; bytes 1D, 1D, F0, 1D -> bitmap 0x1, then 0x0; exactly two events: press idx0, release idx0.
- Program slot 3 = {en,1,75}; bytes E0, 75, E0, F0, 75 -> bitmap bit3 set then cleared. A plain 75 with no E0 produces no event.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1D -> only the final 1D produces an event.
- Nine distinct presses with FIFO_DEPTH=8 -> count=8, overflow=1, irq=1. Pop 8 events in order, then the next pop returns 0. Write 0x23=2 -> irq=0.
- Press slot 0, reassign slot 0 over the bus -> pressed bit 0 cleared, no event. Reset asserted between E0 and 75 -> the following 75 is decoded as non-extended.
- Bus pop in the same cycle as an event push with FIFO full -> both accepted; count stays 8; overflow not set.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared constants and types for the PS/2 key tracker.
// Holds scan-code prefixes, decoder states, register addresses, keymap
// field positions and the event record layout.
// Optional feature macro used by the tracker: PS2_KEY_EVENT_FIFO_EN.
package ps2_key_pkg;

  // Scan-code prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Bytes swallowed after the E1 pause prefix
  localparam int unsigned SKIP_W         = 3;
  localparam int unsigned PAUSE_SKIP_LEN = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_t;

  // Register word addresses
  localparam int unsigned REG_PRESSED = 32'h20;
  localparam int unsigned REG_EVENT   = 32'h21;
  localparam int unsigned REG_STATUS  = 32'h22;
  localparam int unsigned REG_CTRL    = 32'h23;

  // Control register bits
  localparam int unsigned CTRL_CLR_MAP = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;
  localparam int unsigned CTRL_FLUSH   = 2;

  // Keymap entry field positions
  localparam int unsigned KM_EN_BIT   = 9;
  localparam int unsigned KM_EXT_BIT  = 8;
  localparam int unsigned KM_CODE_MSB = 7;
  localparam int unsigned KM_CODE_LSB = 0;

  typedef struct packed {
    logic       en;
    logic       ext;
    logic [7:0] code;
  } keymap_t;

  // Event record as stored in the FIFO
  localparam int unsigned EV_IDX_W = 5;

  typedef struct packed {
    logic                press;
    logic [EV_IDX_W-1:0] idx;
  } key_event_t;

  // Event pop readback: valid bit15, press bit8, idx bits4:0
  function automatic logic [15:0] event_word(input key_event_t ev);
    return {1'b1, 6'b0, ev.press, 3'b0, ev.idx};
  endfunction

endpackage

// File: rtl/ps2_code_decoder.sv
// ps2_code_decoder: turns a stream of scan-code bytes into make/break strobes.
// Ports: clk, reset (sync, active-high), code_in/code_valid byte stream;
//        make_c/brk_c/ext_c/code_c are combinational and valid in the cycle
//        carrying the final byte of a sequence.
module ps2_code_decoder
  import ps2_key_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       make_c,
  output logic       brk_c,
  output logic       ext_c,
  output logic [7:0] code_c
);

  dec_state_t        state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt, skip_nxt;

  assign code_c = code_in;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Next state and decode strobes; only a valid byte moves the FSM
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    make_c    = 1'b0;
    brk_c     = 1'b0;
    ext_c     = 1'b0;
    if (code_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (code_in == SC_EXT) begin
            state_nxt = ST_EXT;
          end else if (code_in == SC_BRK) begin
            state_nxt = ST_BRK;
          end else if (code_in == SC_PAUSE) begin
            state_nxt = ST_SKIP;
            skip_nxt  = SKIP_W'(PAUSE_SKIP_LEN);
          end else begin
            make_c = 1'b1;
          end
        end
        ST_EXT: begin
          if (code_in == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (code_in != SC_EXT) begin
            make_c    = 1'b1;
            ext_c     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_c     = 1'b1;
          ext_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          skip_nxt = skip_cnt - SKIP_W'(1);
          // Last swallowed byte returns to IDLE
          if (skip_cnt <= SKIP_W'(1)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 key press tracker with bus-programmable key slots.
// Ports: clk, reset (sync, active-high); code_in/code_valid scan-code bytes;
//        bus_addr/bus_wr/bus_rd/bus_wdata register access; bus_rdata and
//        bus_rvalid one cycle after bus_rd; irq level interrupt.
// Macro PS2_KEY_EVENT_FIFO_EN builds the event FIFO (regs 0x21/0x22, flush);
// without it a sticky "changed" flag drives irq and clears on a 0x20 read.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            code_in,
  input  logic                  code_valid,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_wr,
  input  logic                  bus_rd,
  input  logic [BUS_WIDTH-1:0]  bus_wdata,
  output logic [BUS_WIDTH-1:0]  bus_rdata,
  output logic                  bus_rvalid,
  output logic                  irq
);

  localparam int unsigned SLOT_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic                 dec_make, dec_brk, dec_ext;
  logic [7:0]           dec_code;
  keymap_t              keymap [NUM_KEYS];
  logic [NUM_KEYS-1:0]  pressed, pressed_nxt;
  logic                 hit;
  logic [SLOT_W-1:0]    hit_idx, slot_sel;
  logic                 key_sel, key_wr, ctrl_wr;
  logic                 push;
  key_event_t           push_ev;
  logic [BUS_WIDTH-1:0] rdata_nxt;
  logic                 irq_nxt;
  logic                 unused_wdata;

  assign unused_wdata = ^bus_wdata;

  ps2_code_decoder u_decoder (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .make_c     (dec_make),
    .brk_c      (dec_brk),
    .ext_c      (dec_ext),
    .code_c     (dec_code)
  );

  assign slot_sel = bus_addr[SLOT_W-1:0];
  assign key_sel  = (bus_addr < ADDR_WIDTH'(NUM_KEYS));
  assign key_wr   = bus_wr && key_sel;
  assign ctrl_wr  = bus_wr && (bus_addr == ADDR_WIDTH'(REG_CTRL));

  // Parallel keymap match; descending scan leaves the lowest index winning
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keymap[i].en && keymap[i].ext == dec_ext && keymap[i].code == dec_code) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
  end

  // Bitmap update and event generation; bus clears override decode
  always_comb begin
    pressed_nxt = pressed;
    push        = 1'b0;
    push_ev     = '0;
    if (hit && dec_make && !pressed[hit_idx]) begin
      pressed_nxt[hit_idx] = 1'b1;
      push                 = 1'b1;
      push_ev              = '{press: 1'b1, idx: EV_IDX_W'(hit_idx)};
    end else if (hit && dec_brk && pressed[hit_idx]) begin
      pressed_nxt[hit_idx] = 1'b0;
      push                 = 1'b1;
      push_ev              = '{press: 1'b0, idx: EV_IDX_W'(hit_idx)};
    end
    if (key_wr) pressed_nxt[slot_sel] = 1'b0;
    if (ctrl_wr && bus_wdata[CTRL_CLR_MAP]) pressed_nxt = '0;
  end

  // Keymap, bitmap and bus response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) keymap[i] <= '0;
      pressed    <= '0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (key_wr) begin
        keymap[slot_sel] <= '{en:   bus_wdata[KM_EN_BIT],
                              ext:  bus_wdata[KM_EXT_BIT],
                              code: bus_wdata[KM_CODE_MSB:KM_CODE_LSB]};
      end
      pressed    <= pressed_nxt;
      bus_rdata  <= rdata_nxt;
      bus_rvalid <= bus_rd;
      irq        <= irq_nxt;
    end
  end

`ifdef PS2_KEY_EVENT_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  key_event_t       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             overflow, overflow_nxt;
  logic             pop, flush, accept;

  assign pop    = bus_rd && (bus_addr == ADDR_WIDTH'(REG_EVENT)) && (count != '0);
  assign flush  = ctrl_wr && bus_wdata[CTRL_FLUSH];
  // A simultaneous pop frees the slot the push needs
  assign accept = push && !flush && ((count != CNT_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (accept && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !accept) begin
      count_nxt = count - CNT_W'(1);
    end
    overflow_nxt = (overflow && !(ctrl_wr && bus_wdata[CTRL_CLR_OVF])) ||
                   (push && !flush && !accept);
    irq_nxt = (count_nxt != '0) || overflow_nxt;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= push_ev;
  end

  // FIFO pointers and status
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Read mux
  always_comb begin
    rdata_nxt = '0;
    if (bus_rd) begin
      if (key_sel) begin
        rdata_nxt = BUS_WIDTH'(keymap[slot_sel]);
      end else if (bus_addr == ADDR_WIDTH'(REG_PRESSED)) begin
        rdata_nxt = BUS_WIDTH'(pressed);
      end else if (bus_addr == ADDR_WIDTH'(REG_EVENT)) begin
        if (count != '0) rdata_nxt = BUS_WIDTH'(event_word(fifo_mem[rd_ptr]));
      end else if (bus_addr == ADDR_WIDTH'(REG_STATUS)) begin
        rdata_nxt = BUS_WIDTH'({overflow, 8'(count)});
      end
    end
  end
`else
  logic changed, changed_nxt;
  logic unused_ev;

  assign unused_ev = ^{push, push_ev};

  // Sticky flag: any bitmap change sets it, a bitmap read clears it
  always_comb begin
    changed_nxt = (changed && !(bus_rd && bus_addr == ADDR_WIDTH'(REG_PRESSED))) ||
                  (pressed_nxt != pressed);
    irq_nxt     = changed_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) changed <= 1'b0;
    else       changed <= changed_nxt;
  end

  // Read mux
  always_comb begin
    rdata_nxt = '0;
    if (bus_rd) begin
      if (key_sel) begin
        rdata_nxt = BUS_WIDTH'(keymap[slot_sel]);
      end else if (bus_addr == ADDR_WIDTH'(REG_PRESSED)) begin
        rdata_nxt = BUS_WIDTH'(pressed);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: scoreboard bench for ps2_key_tracker.
// Reads push their expected data into a queue; a monitor compares on bus_rvalid.
module tb_ps2_key_tracker;

  localparam int NK = 16;
  localparam int FD = 8;
  localparam int BW = 32;
  localparam int AW = 6;
`ifdef PS2_KEY_EVENT_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    code_in;
  logic          code_valid;
  logic [AW-1:0] bus_addr;
  logic          bus_wr;
  logic          bus_rd;
  logic [BW-1:0] bus_wdata;
  logic [BW-1:0] bus_rdata;
  logic          bus_rvalid;
  logic          irq;

  ps2_key_tracker #(
    .NUM_KEYS   (NK),
    .FIFO_DEPTH (FD),
    .BUS_WIDTH  (BW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [9:0]  m_km [NK];
  logic [31:0] m_pressed;
  bit          m_ext, m_brk;
  int          m_skip;
  int          m_evq[$];
  bit          m_ovf, m_changed;

  logic [31:0] exp_q[$];
  int          exp_addr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void m_reset();
    for (int i = 0; i < NK; i++) m_km[i] = '0;
    m_pressed = '0;
    m_ext = 0; m_brk = 0; m_skip = 0;
    m_evq.delete();
    m_ovf = 0; m_changed = 0;
  endfunction

  function automatic void m_push(input int press, input int idx);
    m_changed = 1;
    if (FIFO_EN) begin
      if (m_evq.size() < FD) m_evq.push_back((press << 8) | idx);
      else m_ovf = 1;
    end
  endfunction

  function automatic void m_key(input bit make, input bit ext, input logic [7:0] code);
    int hit = -1;
    for (int i = 0; i < NK; i++)
      if (hit < 0 && m_km[i][9] && m_km[i][8] == ext && m_km[i][7:0] == code) hit = i;
    if (hit < 0) return;
    if (make && !m_pressed[hit]) begin
      m_pressed[hit] = 1'b1; m_push(1, hit);
    end else if (!make && m_pressed[hit]) begin
      m_pressed[hit] = 1'b0; m_push(0, hit);
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (m_brk) begin m_key(0, m_ext, b); m_ext = 0; m_brk = 0; end
    else if (b == 8'hE1 && !m_ext) m_skip = 7;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin m_key(1, m_ext, b); m_ext = 0; end
  endfunction

  function automatic void m_write(input int a, input logic [31:0] d);
    if (a < NK) begin
      m_km[a] = d[9:0];
      if (m_pressed[a]) m_changed = 1;
      m_pressed[a] = 1'b0;
    end else if (a == 'h23) begin
      if (d[0] && m_pressed != 0) m_changed = 1;
      if (d[0]) m_pressed = '0;
      if (d[1]) m_ovf = 0;
      if (d[2]) m_evq.delete();
    end
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    if (a < NK) return {22'b0, m_km[a]};
    if (a == 'h20) return m_pressed;
    if (a == 'h21 && FIFO_EN && m_evq.size() > 0) return 32'h8000 | m_evq[0];
    if (a == 'h22 && FIFO_EN) return (int'(m_ovf) << 8) | m_evq.size();
    return 0;
  endfunction

  function automatic void m_read_effect(input int a);
    if (a == 'h21 && FIFO_EN && m_evq.size() > 0) void'(m_evq.pop_front());
    if (a == 'h20) m_changed = 0;
  endfunction

  function automatic bit m_irq();
    return FIFO_EN ? (m_evq.size() > 0 || m_ovf) : m_changed;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1; code_valid = 0; bus_rd = 0; bus_wr = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    code_in = b; code_valid = 1;
    m_byte(b);
    @(negedge clk);
    code_valid = 0;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = AW'(a); bus_wdata = d; bus_wr = 1;
    m_write(a, d);
    @(negedge clk);
    bus_wr = 0;
  endtask

  task automatic bus_read(input int a);
    @(negedge clk);
    bus_addr = AW'(a); bus_rd = 1;
    exp_q.push_back(exp_read(a)); exp_addr_q.push_back(a);
    m_read_effect(a);
    @(negedge clk);
    bus_rd = 0;
  endtask

  // Read and a scan-code byte in the same cycle
  task automatic read_with_byte(input int a, input logic [7:0] b);
    @(negedge clk);
    bus_addr = AW'(a); bus_rd = 1; code_in = b; code_valid = 1;
    exp_q.push_back(exp_read(a)); exp_addr_q.push_back(a);
    m_read_effect(a);
    m_byte(b);
    @(negedge clk);
    bus_rd = 0; code_valid = 0;
  endtask

  task automatic check_irq(input string name);
    n_checks++;
    if (irq !== m_irq()) begin
      n_fail++;
      $display("FAIL %s: irq got %0b want %0b", name, irq, m_irq());
    end
  endtask

  // Monitor: compare every read response against the scoreboard
  logic [31:0] mon_exp;
  int          mon_addr;
  always @(negedge clk) begin
    if (bus_rvalid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid: rdata got %h with no read pending", bus_rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_addr = exp_addr_q.pop_front();
        if (bus_rdata !== mon_exp) begin
          n_fail++;
          $display("FAIL read_0x%0h: rdata got %h want %h", mon_addr, bus_rdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] alpha [16] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1D, 8'h75, 8'h14, 8'h77,
                             8'h1C, 8'h1D, 8'h75, 8'h14, 8'h77, 8'h1C, 8'h1B, 8'hE1};
  logic [7:0] kcodes [6] = '{8'h1D, 8'h75, 8'h14, 8'h77, 8'h1C, 8'hE0};

  initial begin
    reset = 1; code_in = 0; code_valid = 0;
    bus_addr = 0; bus_wr = 0; bus_rd = 0; bus_wdata = 0;
    m_reset();
    do_reset();

    // Reset values
    n_checks++;
    if (bus_rdata !== '0 || bus_rvalid !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%h rvalid=%0b irq=%0b want 0/0/0",
               bus_rdata, bus_rvalid, irq);
    end
    bus_read('h20); bus_read('h22); bus_read(0);

    // Plain make, typematic repeat, break
    bus_write(0, 32'h21D);
    send_byte(8'h1D); bus_read('h20);
    check_irq("press_irq");
    send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1D);
    bus_read('h20); bus_read('h21); bus_read('h21); bus_read('h21);
    check_irq("after_pops");

    // Extended key; plain 75 must not match
    bus_write(3, 32'h375);
    send_byte(8'h75); bus_read('h20);
    send_byte(8'hE0); send_byte(8'h75); bus_read('h20);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); bus_read('h20);
    bus_read('h21); bus_read('h21); bus_read(3);

    // Pause sequence swallowed, following 1D decoded
    bus_write(1, 32'h214); bus_write(2, 32'h277);
    foreach (alpha[i]) if (0) ;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    bus_read('h20);
    send_byte(8'h1D); bus_read('h20); bus_read('h21); bus_read('h21);

    // Nine presses into an eight-entry FIFO
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(i, 32'h200 | (32'h15 + i));
    for (int i = 0; i < 9; i++) send_byte(8'(8'h15 + i));
    bus_read('h22); bus_read('h20);
    check_irq("overflow_irq");
    for (int i = 0; i < 9; i++) bus_read('h21);
    bus_write('h23, 32'h2);
    check_irq("ovf_cleared_irq");
    bus_read('h22);

    // Fill with releases, then pop and push in the same cycle
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hF0); send_byte(8'(8'h15 + i));
    end
    send_byte(8'hF0);
    read_with_byte('h21, 8'h1D);
    bus_read('h22); bus_read('h20);
    check_irq("pop_push_irq");
    bus_write('h23, 32'h5);
    bus_read('h22); bus_read('h20);
    check_irq("flush_irq");

    // Reassign a pressed slot; reset between E0 and 75
    do_reset();
    bus_write(0, 32'h21D);
    send_byte(8'h1D);
    bus_write(0, 32'h21C);
    bus_read('h20); bus_read('h21); bus_read('h21);
    send_byte(8'hE0);
    do_reset();
    bus_write(1, 32'h275); bus_write(2, 32'h375);
    send_byte(8'h75);
    bus_read('h20); bus_read('h21);
    check_irq("post_reset_irq");

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 8; i++)
      bus_write(i, 32'h200 | {$urandom_range(0, 1), kcodes[$urandom_range(0, 4)]});
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        send_byte(alpha[$urandom_range(0, 15)]);
      end else if (r < 60) begin
        d = $urandom;
        d[7:0] = kcodes[$urandom_range(0, 5)];
        bus_write($urandom_range(0, NK - 1), d);
      end else if (r < 64) begin
        bus_write($urandom_range(NK, 63), $urandom);
      end else if (r < 88) begin
        bus_read('h20 + $urandom_range(0, 2));
      end else begin
        bus_read($urandom_range(0, 63));
      end
      if (it % 4 == 0) check_irq("random_irq");
    end

    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_responses: %0d missing want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
